// File: rtl/pcie_phy_tx_framer.sv
// pcie_phy_tx_framer
//   Frames the merged TLP/DLLP AXI-Stream from the datalink arbiter into a
//   Gen1/Gen2 byte stream for the PHY logical layer. Each packet is wrapped
//   as STP|SDP ... END|EDB, and bytes are re-packed across beats through a
//   one-byte carry. A per-byte K flag marks the framing tokens.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   s_axis_*              input packet stream (tuser[0]=DLLP, tuser[1]=nullify)
//   m_axis_*              framed output stream, m_axis_datak = K-symbol flags
//   tlp_count_o           framed TLPs (wrapping)
//   dllp_count_o          framed DLLPs (wrapping)
//   dllp_len_err_o        pulse on a DLLP tlast accept when its length != 6
module pcie_phy_tx_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [KEEP_WIDTH-1:0] m_axis_datak,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           tlp_count_o,
  output logic [15:0]           dllp_count_o,
  output logic                  dllp_len_err_o
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_FLUSH} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]            r_carry;
  logic                  r_is_dllp;
  logic [2:0]            r_len;
  logic [7:0]            r_end;
  logic                  r_fl_k4;

  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_WIDTH-1:0] r_m_tkeep;
  logic [KEEP_WIDTH-1:0] r_m_datak;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_m_dllp;
  logic [15:0]           r_tlp_cnt;
  logic [15:0]           r_dllp_cnt;

  logic                  w_out_free;
  logic                  w_acc;
  logic                  w_first;
  logic                  w_is_dllp;
  logic [7:0]            w_carry;
  logic [7:0]            w_end;
  logic [2:0]            w_nk;
  logic [3:0]            w_len_sum;
  logic [2:0]            w_len_tot;
  logic                  w_need_flush;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic [KEEP_WIDTH-1:0] w_beat_keep;
  logic [KEEP_WIDTH-1:0] w_beat_k;
  logic                  w_unused_user;

  assign w_unused_user = ^s_axis_tuser[USER_WIDTH-1:2];

  assign w_out_free    = !r_m_tvalid || m_axis_tready;
  assign s_axis_tready = !rst_i && (r_state != S_FLUSH) && w_out_free;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_first       = (r_state == S_IDLE);

  // In IDLE the carry slot is virtually preloaded with the start token, so the
  // first beat goes through the same byte shift as a body beat.
  assign w_is_dllp = w_first ? s_axis_tuser[0] : r_is_dllp;
  assign w_carry   = w_first ? (s_axis_tuser[0] ? K_SDP : K_STP) : r_carry;
  // Nullify only means anything for TLPs.
  assign w_end     = (!w_is_dllp && s_axis_tuser[1]) ? K_EDB : K_END;

  // tkeep is contiguous from bit0, so the highest set bit gives the count.
  always_comb begin
    w_nk = 3'd0;
    for (int b = 0; b < KEEP_WIDTH; b++)
      if (s_axis_tkeep[b]) w_nk = 3'(b + 1);
  end

  assign w_len_sum    = {1'b0, (w_first ? 3'd0 : r_len)} + {1'b0, w_nk};
  assign w_len_tot    = (w_len_sum > 4'd7) ? 3'd7 : w_len_sum[2:0];
  assign w_need_flush = s_axis_tlast && (w_nk >= 3'd3);

  assign dllp_len_err_o = w_acc && s_axis_tlast && w_is_dllp && (w_len_tot != 3'd6);

  // Output beat = {in[2:0], carry}; on a short tlast beat the end token lands
  // right after the last payload byte.
  always_comb begin
    w_beat_data       = '0;
    w_beat_keep       = '0;
    w_beat_k          = '0;
    w_beat_data[7:0]  = w_carry;
    w_beat_keep[0]    = 1'b1;
    w_beat_k[0]       = w_first;
    for (int j = 1; j < KEEP_WIDTH; j++) begin
      if (!s_axis_tlast || (j - 1) < int'(w_nk)) begin
        w_beat_data[8*j +: 8] = s_axis_tdata[8*(j-1) +: 8];
        w_beat_keep[j]        = 1'b1;
      end else if ((j - 1) == int'(w_nk)) begin
        w_beat_data[8*j +: 8] = w_end;
        w_beat_keep[j]        = 1'b1;
        w_beat_k[j]           = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_BODY: begin
        if (w_acc) begin
          if (!s_axis_tlast)     w_state_nxt = S_BODY;
          else if (w_need_flush) w_state_nxt = S_FLUSH;
          else                   w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: if (w_out_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_carry    <= '0;
      r_is_dllp  <= 1'b0;
      r_len      <= '0;
      r_end      <= '0;
      r_fl_k4    <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_datak  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_dllp   <= 1'b0;
      r_tlp_cnt  <= '0;
      r_dllp_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_carry   <= s_axis_tdata[DATA_WIDTH-1 -: 8];
        r_is_dllp <= w_is_dllp;
        r_len     <= w_len_tot;
        r_end     <= w_end;
        r_fl_k4   <= (w_nk == 3'd4);
      end

      if (w_out_free) begin
        if (r_state == S_FLUSH) begin
          // k=4 leaves {END, in3}; k=3 leaves only the end token.
          r_m_tvalid <= 1'b1;
          r_m_tlast  <= 1'b1;
          r_m_dllp   <= r_is_dllp;
          if (r_fl_k4) begin
            r_m_tdata <= {{(DATA_WIDTH-16){1'b0}}, r_end, r_carry};
            r_m_tkeep <= KEEP_WIDTH'(4'b0011);
            r_m_datak <= KEEP_WIDTH'(4'b0010);
          end else begin
            r_m_tdata <= {{(DATA_WIDTH-8){1'b0}}, r_end};
            r_m_tkeep <= KEEP_WIDTH'(4'b0001);
            r_m_datak <= KEEP_WIDTH'(4'b0001);
          end
        end else if (w_acc) begin
          r_m_tvalid <= 1'b1;
          r_m_tlast  <= s_axis_tlast && !w_need_flush;
          r_m_dllp   <= w_is_dllp;
          r_m_tdata  <= w_beat_data;
          r_m_tkeep  <= w_beat_keep;
          r_m_datak  <= w_beat_k;
        end else begin
          r_m_tvalid <= 1'b0;
        end
      end

      if (r_m_tvalid && m_axis_tready && r_m_tlast) begin
        if (r_m_dllp) r_dllp_cnt <= r_dllp_cnt + 16'd1;
        else          r_tlp_cnt  <= r_tlp_cnt + 16'd1;
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_datak  = r_m_datak;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign tlp_count_o   = r_tlp_cnt;
  assign dllp_count_o  = r_dllp_cnt;

endmodule

// File: tb/tb_pcie_phy_tx_framer.sv
// Scoreboard bench for pcie_phy_tx_framer: a packet-level model turns each
// payload into its framed symbol string and chunks it into 4-byte beats.
module tb_pcie_phy_tx_framer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [2:0]  s_tuser = '0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep, m_datak;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] tlp_cnt, dllp_cnt;
  logic        len_err;

  pcie_phy_tx_framer dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_datak(m_datak),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .tlp_count_o(tlp_cnt), .dllp_count_o(dllp_cnt), .dllp_len_err_o(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  dk;
    logic        l;
    logic        dl;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  pl[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;
  bit          ignore_out = 1'b0;
  bit          cur_dllp = 1'b0;
  int          cur_len = 0;
  logic [15:0] exp_tlp = '0, exp_dllp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: symbol string = start token, payload, end token; cut into
  // 4-byte beats, last beat carries tlast.
  task automatic build_exp(input bit dllp, input bit nul);
    logic [7:0] sym[$];
    bit         kf[$];
    beat_t      b;
    sym.push_back(dllp ? 8'h5C : 8'hFB); kf.push_back(1'b1);
    foreach (pl[i]) begin sym.push_back(pl[i]); kf.push_back(1'b0); end
    sym.push_back((!dllp && nul) ? 8'hFE : 8'hFD); kf.push_back(1'b1);
    for (int i = 0; i < sym.size(); i += 4) begin
      b.d = '0; b.k = '0; b.dk = '0;
      for (int j = 0; j < 4 && i + j < sym.size(); j++) begin
        b.d[8*j +: 8] = sym[i+j];
        b.k[j]        = 1'b1;
        b.dk[j]       = kf[i+j];
      end
      b.l  = (i + 4 >= sym.size());
      b.dl = dllp;
      exp_q.push_back(b);
    end
  endtask

  // Drives the packet in pl; returns on the posedge accepting the last beat.
  task automatic send_pkt(input bit dllp, input bit nul, input int gap);
    int n, nb, rem, t;
    bit acc;
    build_exp(dllp, nul);
    n  = pl.size();
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      #1;
      if (b == 0) begin cur_dllp = dllp; cur_len = n; end
      rem = n - 4*b;
      s_tdata = $urandom;
      s_tkeep = '0;
      for (int j = 0; j < 4 && j < rem; j++) begin
        s_tdata[8*j +: 8] = pl[4*b + j];
        s_tkeep[j] = 1'b1;
      end
      s_tlast    = (b == nb - 1);
      s_tuser    = 3'($urandom);
      if (b == 0) s_tuser[0] = dllp;
      if (s_tlast) s_tuser[1] = nul;
      s_tvalid   = 1'b1;
      t = 0;
      forever begin
        @(negedge clk) acc = s_tready;
        @(posedge clk);
        if (acc) break;
        if (++t > 2000) begin chk("accept_timeout", 0, 1); break; end
      end
    end
    if (gap > 0) begin
      #1 s_tvalid = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic drain();
    int t = 0;
    #1 s_tvalid = 1'b0;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    if (t >= 5000) chk("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
  endtask

  // PHY ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = !m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t e;
    logic [31:0] msk;
    bit exp_err;
    if (!rst_i) begin
      chk("tlp_count", 32'(tlp_cnt), 32'(exp_tlp));
      chk("dllp_count", 32'(dllp_cnt), 32'(exp_dllp));
      exp_err = s_tvalid && s_tready && s_tlast && cur_dllp && (cur_len != 6);
      chk("dllp_len_err", 32'(len_err), 32'(exp_err));
      if (m_tvalid && m_tready && !ignore_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_tdata), 0);
        end else begin
          e = exp_q.pop_front();
          msk = '0;
          for (int j = 0; j < 4; j++) if (e.k[j]) msk[8*j +: 8] = 8'hFF;
          chk("tdata", m_tdata & msk, e.d);
          chk("tkeep", 32'(m_tkeep), 32'(e.k));
          chk("datak", 32'(m_datak), 32'(e.dk));
          chk("tlast", 32'(m_tlast), 32'(e.l));
          if (e.l) begin
            if (e.dl) exp_dllp = exp_dllp + 16'd1;
            else      exp_tlp  = exp_tlp + 16'd1;
          end
        end
      end
    end
  end

  initial begin
    bit d;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", 32'(m_tkeep), 0);
    chk("rst_datak", 32'(m_datak), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_tlp_cnt", 32'(tlp_cnt), 0);
    chk("rst_dllp_cnt", 32'(dllp_cnt), 0);
    chk("rst_len_err", 32'(len_err), 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk);

    // 6-byte DLLP 00..05
    pl = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(1'b1, 1'b0, 2);
    // 4-byte TLP A0..A3 with flush stall check
    pl = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_pkt(1'b0, 1'b0, 0);
    #1 s_tvalid = 1'b0;
    @(negedge clk) chk("flush_tready_low", 32'(s_tready), 0);
    @(negedge clk) chk("flush_tready_back", 32'(s_tready), 1);
    @(posedge clk);
    // nullified 12-byte TLP
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b1, 1);
    // nullify on a DLLP is ignored
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    send_pkt(1'b1, 1'b1, 1);
    // 8-byte DLLP: length error
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    send_pkt(1'b1, 1'b0, 1);
    drain();

    // back-pressure 1010 through a 5-beat TLP
    rdy_mode = 1;
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(8'h40 + i));
    send_pkt(1'b0, 1'b0, 0);
    drain();

    // randomized traffic
    rdy_mode = 2;
    for (int p = 0; p < 300; p++) begin
      d = ($urandom_range(0, 2) == 0);
      if (d) n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 6;
      else   n = $urandom_range(1, 24);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_pkt(d, 1'($urandom), $urandom_range(0, 2));
    end
    drain();

    // reset in the middle of a TLP
    rdy_mode = 0;
    ignore_out = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      s_tdata = $urandom; s_tkeep = 4'hF; s_tlast = 1'b0;
      s_tuser = 3'b000; s_tvalid = 1'b1;
      @(posedge clk);
    end
    #1 rst_i = 1'b1; s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 32'(m_tvalid), 0);
    chk("midrst_tdata", m_tdata, 0);
    chk("midrst_tkeep", 32'(m_tkeep), 0);
    chk("midrst_datak", 32'(m_datak), 0);
    chk("midrst_tlast", 32'(m_tlast), 0);
    chk("midrst_tready", 32'(s_tready), 0);
    chk("midrst_tlp_cnt", 32'(tlp_cnt), 0);
    chk("midrst_dllp_cnt", 32'(dllp_cnt), 0);
    exp_tlp = '0; exp_dllp = '0;
    @(posedge clk);
    #1 rst_i = 1'b0; ignore_out = 1'b0;
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b0, 1);
    drain();

    // DLLP counter wrap using 1-byte DLLPs
    pl = {8'h11};
    for (int p = 0; p < 65535; p++) send_pkt(1'b1, 1'b0, 0);
    drain();
    @(negedge clk) chk("dllp_cnt_ffff", 32'(dllp_cnt), 32'h0000FFFF);
    @(posedge clk);
    send_pkt(1'b1, 1'b0, 0);
    drain();
    @(negedge clk) chk("dllp_cnt_wrap", 32'(dllp_cnt), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_phy_tx_framer.md
# pcie_phy_tx_framer

Downstream stage of the PCIe datalink layer: consumes the merged TLP/DLLP AXI-Stream leaving the datalink arbiter and emits an 8b/10b-era (Gen1/Gen2) framed byte stream toward the PHY logical layer. Each packet is wrapped in K-symbols:
- start token: STP for TLPs, SDP for DLLPs;
- end token: END normally, EDB for nullified TLPs.

Bytes are re-packed across beat boundaries, a per-byte K flag is generated, and per-type packet counts plus a DLLP length check are kept.

## Interface
Parameters:
- DATA_WIDTH, 32, stream width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte enables per beat.
- USER_WIDTH, 3, input sideband width; bit0 = DLLP (1) / TLP (0), bit1 = nullify, sampled on the tlast beat.

Ports (one clock `clk_i`; reset `rst_i` is synchronous, active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  packet bytes; byte0 = tdata[7:0], sent first.
- s_axis_tkeep  in  KEEP_WIDTH  contiguous from bit0; all-ones except on the tlast beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tuser  in  USER_WIDTH  type/nullify sideband.
- s_axis_tready  out  1  beat accept.
- m_axis_tdata  out  DATA_WIDTH  framed bytes.
- m_axis_tkeep  out  KEEP_WIDTH  valid bytes; partial only on the tlast beat.
- m_axis_datak  out  KEEP_WIDTH  per-byte K-symbol flag.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  beat carries the end token.
- m_axis_tready  in  1  PHY accept.
- tlp_count_o  out  16  framed TLPs, wraps at 0xFFFF→0.
- dllp_count_o  out  16  framed DLLPs, wraps at 0xFFFF→0.
- dllp_len_err_o  out  1  one-cycle pulse: a DLLP was not exactly 6 bytes.

## Operation
- Symbols:
  - STP = 0xFB, SDP = 0x5C, END = 0xFD, EDB = 0xFE.
  - datak = 1 only on these four bytes.
- Type is taken from s_axis_tuser[0] on the first beat. Nullify is taken from tuser[1] on the tlast beat; it is honoured for TLPs only and ignored for DLLPs.
- Carry register holds exactly 1 byte between beats. On the first beat it is loaded with the start token, so first and body beats are handled identically.
- Full input beat (k=4 bytes) → output {in[2:0], carry}; carry ← in byte3.
- tlast beat with k bytes gives 1 + k + 1 total bytes:
  - k ≤ 2: one output beat, tkeep = low (k+2) bits, end token at byte k+1, tlast = 1.
  - k ∈ {3, 4}: one full beat without tlast, then a FLUSH beat holding the remaining (k−2) bytes. The end token is the last of them; tkeep = low (k−2) bits; tlast = 1.
- FSM:
  - IDLE → BODY on the accepted first beat without tlast.
  - IDLE/BODY → IDLE on an accepted tlast beat with k ≤ 2.
  - IDLE/BODY → FLUSH on an accepted tlast beat with k ≥ 3.
  - FLUSH → IDLE when the flush beat is accepted.
  - Single-beat packets go straight from IDLE.
- Counters increment by 1 when the output beat with tlast is accepted. EDB-terminated TLPs are still counted.
- DLLP length check:
  - Byte total is accumulated in a 3-bit saturating count at 7.
  - dllp_len_err_o pulses on the cycle the DLLP's tlast input beat is accepted if the total ≠ 6.
  - The packet is still framed and forwarded.

## Timing
- Registered output; latency 1 cycle from input accept to output valid.
- s_axis_tready = (state ≠ FLUSH) && (!m_axis_tvalid || m_axis_tready). No combinational path from s_axis_tvalid to m_axis_*.
- Output fields hold stable while m_axis_tvalid && !m_axis_tready.
- Back-to-back packets: the first beat of the next packet may be accepted in the cycle the previous tlast beat (k ≤ 2) or flush beat is accepted; no idle beat is inserted.
- Input is stalled for exactly one cycle per FLUSH beat when the PHY is ready.
- Reset values: m_axis_tvalid, tdata, tkeep, datak, tlast = 0; s_axis_tready = 0 during reset; counters = 0; dllp_len_err_o = 0; state IDLE; carry = 0.
- Reset mid-packet discards the partial packet. The cycle after reset deasserts, the next beat is treated as a first beat.

## Test plan
- DLLP, 6 bytes 0x00..0x05 (beat0 keep 1111, beat1 keep 0011 last, tuser=001):
  - out beat0 = 0x0201005C, datak 0001, keep 1111;
  - out beat1 = 0xFD050403, datak 1000, keep 1111, last;
  - dllp_count_o = 1, no len_err.
- TLP, 4 bytes 0xA0..0xA3, single beat keep 1111 last:
  - out 0xA2A1A0FB (datak 0001), then flush 0x----FDA3 with keep 0011, datak 0010, last;
  - tready low during flush; tlp_count_o = 1.
- Nullified TLP, 12 bytes, tlast keep 1111, tuser=010: final flush byte1 = 0xFE (EDB), datak 0010.
- Back-pressure: m_axis_tready toggled 1010 through a 5-beat TLP → byte stream identical to the no-stall run, no beat dropped or duplicated.
- DLLP of 8 bytes: dllp_len_err_o pulses once, packet framed SDP…END, dllp_count_o increments.
- Counter wrap and reset: preload 0xFFFF via 65535 DLLPs, one more gives 0x0000. Assert rst_i mid-TLP: outputs 0, next packet framed cleanly starting with STP.
